comparator_checker: RTL and testbench

COMPARATOR_CHECKER -- requirements
Module: comparator_checker

---
 rtl/comparator_checker.sv | 119 +++++++++++
 tb/tb_comparator_checker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_checker.sv
// Scoreboard for a WIDTH-bit magnitude comparator: recomputes the expected
// {grth,lsth,eq,none} code for each accepted (a,b) sample, counts matches and
// mismatches, and captures the first failing sample.
module comparator_checker #(
  parameter int WIDTH       = 3,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             grth,
  input  logic             lsth,
  input  logic             eq,
  input  logic             none,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_flag,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic [3:0]       err_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [CNT_W-1:0] n_lim;    // run length captured at start
  logic [CNT_W-1:0] acc_cnt;  // samples accepted this run
  logic [3:0]       got_code;
  logic [3:0]       exp_code;
  logic             accept;
  logic             match;
  logic             last;

  // Handshake and status are pure decodes of the state register.
  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE) || (state == S_HALT);

  assign got_code = {grth, lsth, eq, none};
  assign accept   = in_valid && in_ready;
  assign match    = (got_code == exp_code);
  // Zero run length means unlimited, so it never terminates the run.
  assign last     = (n_lim != '0) && ((acc_cnt + ONE) == n_lim);

  // Reference model: unsigned compare yields exactly one flag, never none.
  always_comb begin
    exp_code = 4'b0010;
    if (a > b)      exp_code = 4'b1000;
    else if (a < b) exp_code = 4'b0100;
  end

  // Run control, scoring and first-error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      n_lim    <= '0;
      acc_cnt  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_flag <= 1'b0;
      err_a    <= '0;
      err_b    <= '0;
      err_code <= 4'b0000;
    end else begin
      case (state)
        S_RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + ONE;
            if (match) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + ONE;
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + ONE;
              err_flag <= 1'b1;
              if (!err_flag) begin
                err_a    <= a;
                err_b    <= b;
                err_code <= got_code;
              end
            end
            // A halting mismatch outranks end-of-run on the same sample.
            if (!match && (STOP_ON_ERR != 0)) state <= S_HALT;
            else if (last || stop)            state <= S_DONE;
          end else if (stop) begin
            state <= S_DONE;
          end
        end
        default: begin
          // IDLE, DONE and HALT all restart identically; stop is ignored here.
          if (start) begin
            state    <= S_RUN;
            n_lim    <= num_samples;
            acc_cnt  <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err_flag <= 1'b0;
            err_a    <= '0;
            err_b    <= '0;
            err_code <= 4'b0000;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_checker.sv
// Directed bench for comparator_checker: a default instance, a STOP_ON_ERR
// instance and a 2-bit counter instance share one stimulus stream.
module tb_comparator_checker;

  logic        clk = 1'b0;
  logic        rst, start, stop, in_valid;
  logic [15:0] num_samples;
  logic [2:0]  a, b;
  logic        grth, lsth, eq, none;

  logic        d_ready, d_busy, d_done, d_err;
  logic [15:0] d_pass, d_fail;
  logic [2:0]  d_ea, d_eb;
  logic [3:0]  d_code;

  logic        h_ready, h_busy, h_done, h_err;
  logic [15:0] h_pass, h_fail;
  logic [2:0]  h_ea, h_eb;
  logic [3:0]  h_code;

  logic        s_ready, s_busy, s_done, s_err;
  logic [1:0]  s_pass, s_fail;
  logic [2:0]  s_ea, s_eb;
  logic [3:0]  s_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  comparator_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(d_ready), .a(a), .b(b),
    .grth(grth), .lsth(lsth), .eq(eq), .none(none),
    .busy(d_busy), .done(d_done), .pass_cnt(d_pass), .fail_cnt(d_fail),
    .err_flag(d_err), .err_a(d_ea), .err_b(d_eb), .err_code(d_code));

  comparator_checker #(.STOP_ON_ERR(1)) u_soe (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(h_ready), .a(a), .b(b),
    .grth(grth), .lsth(lsth), .eq(eq), .none(none),
    .busy(h_busy), .done(h_done), .pass_cnt(h_pass), .fail_cnt(h_fail),
    .err_flag(h_err), .err_a(h_ea), .err_b(h_eb), .err_code(h_code));

  comparator_checker #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_samples(num_samples[1:0]),
    .in_valid(in_valid), .in_ready(s_ready), .a(a), .b(b),
    .grth(grth), .lsth(lsth), .eq(eq), .none(none),
    .busy(s_busy), .done(s_done), .pass_cnt(s_pass), .fail_cnt(s_fail),
    .err_flag(s_err), .err_a(s_ea), .err_b(s_eb), .err_code(s_code));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [2:0] av, input logic [2:0] bv, input logic [3:0] code);
    a = av; b = bv; {grth, lsth, eq, none} = code; in_valid = 1'b1;
  endtask

  task automatic begin_run(input logic [15:0] n);
    start = 1'b1; num_samples = n; in_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; num_samples = 16'd0;
    smp(3'd1, 3'd2, 4'b0100);
    tick(); tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({d_ready, d_busy, d_done, d_pass, d_fail, d_err, d_ea, d_eb, d_code} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b busy=%b done=%b pass=%0d fail=%0d err=%b ea=%0d eb=%0d code=%b want all 0",
               d_ready, d_busy, d_done, d_pass, d_fail, d_err, d_ea, d_eb, d_code);
    end
    n_checks++;
    if ({h_ready, h_done, s_ready, s_done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_other_inst got %b want 0000", {h_ready, h_done, s_ready, s_done});
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1; num_samples = 16'd2;
    tick();
    start = 1'b0; stop = 1'b0;
    n_checks++;
    if ({d_busy, d_ready, d_done} !== 3'b110) begin
      n_fail++; $display("FAIL start_beats_stop got busy/rdy/done=%b want 110", {d_busy, d_ready, d_done});
    end
    tick();
    n_checks++;
    if (d_pass !== 16'd0 || d_busy !== 1'b1) begin
      n_fail++; $display("FAIL invalid_ignored got pass=%0d busy=%b want 0 1", d_pass, d_busy);
    end
    smp(3'd7, 3'd7, 4'b0010); tick();
    smp(3'd0, 3'd7, 4'b0100); tick();
    in_valid = 1'b0;
    n_checks++;
    if (d_pass !== 16'd2 || d_done !== 1'b1 || d_busy !== 1'b0) begin
      n_fail++; $display("FAIL run_len2 got pass=%0d done=%b busy=%b want 2 1 0", d_pass, d_done, d_busy);
    end
  endtask

  task automatic test_clean_run();
    begin_run(16'd3);
    num_samples = 16'd1;  // must not shorten the run already started
    smp(3'd5, 3'd2, 4'b1000); tick();
    n_checks++;
    if (d_pass !== 16'd1 || d_busy !== 1'b1) begin
      n_fail++; $display("FAIL clean_first got pass=%0d busy=%b want 1 1", d_pass, d_busy);
    end
    smp(3'd1, 3'd6, 4'b0100); tick();
    smp(3'd4, 3'd4, 4'b0010); tick();
    in_valid = 1'b0;
    n_checks++;
    if (d_pass !== 16'd3 || d_fail !== 16'd0 || d_err !== 1'b0 || d_done !== 1'b1 || d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_run got pass=%0d fail=%0d err=%b done=%b rdy=%b want 3 0 0 1 0",
               d_pass, d_fail, d_err, d_done, d_ready);
    end
  endtask

  task automatic test_mismatch();
    begin_run(16'd0);
    smp(3'd3, 3'd3, 4'b1000); tick();
    n_checks++;
    if (d_fail !== 16'd1 || d_err !== 1'b1 || d_ea !== 3'd3 || d_eb !== 3'd3 || d_code !== 4'b1000 || d_pass !== 16'd0) begin
      n_fail++;
      $display("FAIL first_mismatch got fail=%0d err=%b ea=%0d eb=%0d code=%b pass=%0d want 1 1 3 3 1000 0",
               d_fail, d_err, d_ea, d_eb, d_code, d_pass);
    end
    smp(3'd1, 3'd2, 4'b0001); tick();
    n_checks++;
    if (d_fail !== 16'd2 || d_ea !== 3'd3 || d_eb !== 3'd3 || d_code !== 4'b1000) begin
      n_fail++;
      $display("FAIL second_mismatch_kept got fail=%0d ea=%0d eb=%0d code=%b want 2 3 3 1000", d_fail, d_ea, d_eb, d_code);
    end
    start = 1'b1; smp(3'd6, 3'd1, 4'b1000); tick();
    start = 1'b0;
    n_checks++;
    if (d_pass !== 16'd1 || d_fail !== 16'd2 || d_err !== 1'b1) begin
      n_fail++; $display("FAIL start_in_run got pass=%0d fail=%0d err=%b want 1 2 1", d_pass, d_fail, d_err);
    end
    smp(3'd2, 3'd2, 4'b0011); tick();
    n_checks++;
    if (d_fail !== 16'd3) begin
      n_fail++; $display("FAIL multi_flag got fail=%0d want 3", d_fail);
    end
    stop = 1'b1; smp(3'd0, 3'd0, 4'b0010); tick();
    stop = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (d_pass !== 16'd2 || d_done !== 1'b1 || d_busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_scores got pass=%0d done=%b busy=%b want 2 1 0", d_pass, d_done, d_busy);
    end
  endtask

  task automatic test_stop_on_err();
    begin_run(16'd0);
    smp(3'd3, 3'd3, 4'b1000); tick();
    n_checks++;
    if (h_fail !== 16'd1 || h_done !== 1'b1 || h_busy !== 1'b0 || h_ready !== 1'b0 || h_err !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_entry got fail=%0d done=%b busy=%b rdy=%b err=%b want 1 1 0 0 1",
               h_fail, h_done, h_busy, h_ready, h_err);
    end
    smp(3'd5, 3'd1, 4'b1000); tick();
    smp(3'd2, 3'd2, 4'b1000); tick();
    in_valid = 1'b0;
    n_checks++;
    if (h_fail !== 16'd1 || h_pass !== 16'd0 || h_ready !== 1'b0) begin
      n_fail++; $display("FAIL halt_frozen got fail=%0d pass=%0d rdy=%b want 1 0 0", h_fail, h_pass, h_ready);
    end
    n_checks++;
    if (d_busy !== 1'b1 || d_fail !== 16'd2 || d_pass !== 16'd1) begin
      n_fail++; $display("FAIL no_halt_default got busy=%b fail=%0d pass=%0d want 1 2 1", d_busy, d_fail, d_pass);
    end
    begin_run(16'd0);
    n_checks++;
    if (h_busy !== 1'b1 || h_fail !== 16'd0 || h_err !== 1'b0 || h_code !== 4'b0 || h_ea !== 3'd0) begin
      n_fail++;
      $display("FAIL halt_restart got busy=%b fail=%0d err=%b code=%b ea=%0d want 1 0 0 0000 0", h_busy, h_fail, h_err, h_code, h_ea);
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_saturation();
    begin_run(16'd0);
    for (int i = 0; i < 5; i++) begin
      smp(3'(i + 1), 3'd0, 4'b1000); tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (s_pass !== 2'd3 || s_busy !== 1'b1 || d_pass !== 16'd5) begin
      n_fail++; $display("FAIL saturate got s_pass=%0d s_busy=%b d_pass=%0d want 3 1 5", s_pass, s_busy, d_pass);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    n_checks++;
    if (s_pass !== 2'd3 || s_done !== 1'b1) begin
      n_fail++; $display("FAIL saturate_stop got pass=%0d done=%b want 3 1", s_pass, s_done);
    end
  endtask

  task automatic test_reset_mid_run();
    begin_run(16'd0);
    smp(3'd1, 3'd0, 4'b1000); tick();
    smp(3'd0, 3'd1, 4'b0100); tick();
    n_checks++;
    if (d_pass !== 16'd2) begin
      n_fail++; $display("FAIL pre_reset got pass=%0d want 2", d_pass);
    end
    rst = 1'b1; smp(3'd4, 3'd4, 4'b0010); tick();
    rst = 1'b0; in_valid = 1'b0; tick();
    n_checks++;
    if ({d_ready, d_busy, d_done, d_pass, d_fail, d_err, d_ea, d_eb, d_code} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run got rdy=%b busy=%b done=%b pass=%0d fail=%0d err=%b want all 0",
               d_ready, d_busy, d_done, d_pass, d_fail, d_err);
    end
    rst = 1'b1; start = 1'b1; tick();
    rst = 1'b0; start = 1'b0;
    n_checks++;
    if ({d_busy, d_done, d_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_beats_start got busy/done/rdy=%b want 000", {d_busy, d_done, d_ready});
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] code;
    begin_run(16'd64);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        code = (i > j) ? 4'b1000 : (i < j) ? 4'b0100 : 4'b0010;
        smp(3'(i), 3'(j), code); tick();
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (d_pass !== 16'd64 || d_fail !== 16'd0 || d_done !== 1'b1) begin
      n_fail++; $display("FAIL exhaustive got pass=%0d fail=%0d done=%b want 64 0 1", d_pass, d_fail, d_done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; num_samples = '0;
    a = '0; b = '0; {grth, lsth, eq, none} = 4'b0;
    test_reset();
    test_start_stop_idle();
    test_clean_run();
    test_mismatch();
    test_stop_on_err();
    test_saturation();
    test_reset_mid_run();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
